// File: rtl/imm_encode_loader_pkg.sv
// Shared definitions for the immediate-encoding program loader.
//   - immsrc selector encodings (IMM_I, IMM_S, IMM_B, IMM_J)
//   - loader FSM state enum
//   - ADDR_STEP: byte distance between consecutive instruction words
package imm_encode_loader_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int ADDR_STEP = 4;

endpackage

// File: rtl/imm_encode_loader_insert.sv
// imm_insert: combinational inverse of the immediate extender.
// Range-checks a signed immediate for the selected format and scatters its
// bits into the template's immediate fields; all other template bits pass
// through unchanged.
// Optional feature macro: IMM_J_TYPE_EN (immsrc=11 encodes J-type;
// otherwise immsrc=11 never fits).
// Ports:
//   templ_i  [31:0] template instruction word
//   imm_i    [31:0] signed immediate
//   immsrc_i [1:0]  format selector
//   word_o   [31:0] encoded instruction word
//   fits_o          immediate is representable in the selected format
module imm_insert
  import imm_encode_loader_pkg::*;
(
  input  logic [31:0] templ_i,
  input  logic [31:0] imm_i,
  input  logic [1:0]  immsrc_i,
  output logic [31:0] word_o,
  output logic        fits_o
);

  always_comb begin
    word_o = templ_i;
    fits_o = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        // 12-bit signed: bits 31..11 must all be copies of the sign
        fits_o       = (imm_i[31:11] == {21{imm_i[11]}});
        word_o[31:20] = imm_i[11:0];
      end
      IMM_S: begin
        fits_o        = (imm_i[31:11] == {21{imm_i[11]}});
        word_o[31:25] = imm_i[11:5];
        word_o[11:7]  = imm_i[4:0];
      end
      IMM_B: begin
        // 13-bit signed, even offset
        fits_o        = (imm_i[0] == 1'b0) && (imm_i[31:12] == {20{imm_i[12]}});
        word_o[31]    = imm_i[12];
        word_o[30:25] = imm_i[10:5];
        word_o[11:8]  = imm_i[4:1];
        word_o[7]     = imm_i[11];
      end
      IMM_J: begin
`ifdef IMM_J_TYPE_EN
        // 21-bit signed, even offset
        fits_o        = (imm_i[0] == 1'b0) && (imm_i[31:20] == {12{imm_i[20]}});
        word_o[31]    = imm_i[20];
        word_o[30:21] = imm_i[10:1];
        word_o[20]    = imm_i[11];
        word_o[19:12] = imm_i[19:12];
`else
        fits_o = 1'b0;
`endif
      end
      default: begin
        fits_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode_loader.sv
// imm_encode_loader: boot/test-time program loader. Accepts template +
// immediate beats, encodes the immediate into the template and writes the
// result to instruction memory through one write port.
// Optional feature macro: IMM_J_TYPE_EN (handled inside imm_insert).
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in RUN, so the loader sees in_valid nowhere else.
// Ports:
//   clk, reset (async, active-high)
//   start, start_addr       begin a session (IDLE only) at a word address
//   in_valid/in_ready/in_last, immsrc, imm, templ   input beat stream
//   mem_we, mem_addr, mem_wdata                     instruction-memory write
//   done                    one-cycle pulse at session end
//   wr_count, err_count     per-session counters (saturating)
//   err_sticky              any beat rejected this session
//   state_dbg               current FSM state
module imm_encode_loader
  import imm_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        immsrc,
  input  logic [31:0]       imm,
  input  logic [31:0]       templ,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  output state_e            state_dbg
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              sticky_q, sticky_d;

  logic [31:0] enc_word;
  logic        enc_fits;

  imm_insert u_insert (
    .templ_i  (templ),
    .imm_i    (imm),
    .immsrc_i (immsrc),
    .word_o   (enc_word),
    .fits_o   (enc_fits)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          wr_cnt_d  = '0;
          err_cnt_d = '0;
          sticky_d  = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (enc_fits) begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end else begin
            // Rejected beat: counted, never written, address unchanged
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            sticky_d = 1'b1;
            state_d  = in_last ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(ADDR_STEP);
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        state_d = last_q ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from state so an async reset drops them at once
  assign in_ready   = (state_q == ST_RUN);
  assign mem_we     = (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign wr_count   = wr_cnt_q;
  assign err_count  = err_cnt_q;
  assign err_sticky = sticky_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
module tb_imm_encode_loader;
  import imm_encode_loader_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        immsrc;
  logic [31:0]       imm;
  logic [31:0]       templ;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic [CNT_W-1:0]  wr_count;
  logic [CNT_W-1:0]  err_count;
  logic              err_sticky;
  state_e            state_dbg;

  imm_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .immsrc     (immsrc),
    .imm        (imm),
    .templ      (templ),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .wr_count   (wr_count),
    .err_count  (err_count),
    .err_sticky (err_sticky),
    .state_dbg  (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {address, data}
  logic [31:0] cur_addr;
  int          exp_wr;
  int          exp_err;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write_data got addr=%h data=%h exp addr=%h data=%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Reference encoder, written from the field layout of each format
  function automatic logic [32:0] model(input logic [1:0] src, input logic [31:0] im,
                                        input logic [31:0] tp);
    logic        fit;
    logic [31:0] w;
    int          v;
    v   = int'(im);
    fit = 1'b0;
    w   = tp;
    case (src)
      2'b00: begin
        fit = (v >= -2048) && (v <= 2047);
        w   = {im[11:0], tp[19:0]};
      end
      2'b01: begin
        fit = (v >= -2048) && (v <= 2047);
        w   = {im[11:5], tp[24:12], im[4:0], tp[6:0]};
      end
      2'b10: begin
        fit = (im[0] == 1'b0) && (v >= -4096) && (v <= 4095);
        w   = {im[12], im[10:5], tp[24:12], im[4:1], im[11], tp[6:0]};
      end
      default: begin
`ifdef IMM_J_TYPE_EN
        fit = (im[0] == 1'b0) && (v >= -1048576) && (v <= 1048575);
        w   = {im[20], im[10:1], im[11], im[19:12], tp[11:0]};
`else
        fit = 1'b0;
`endif
      end
    endcase
    return {fit, w};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] a);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    @(negedge clk);
    start      = 1'b0;
    cur_addr   = a;
    exp_wr     = 0;
    exp_err    = 0;
  endtask

  task automatic send_beat(input logic [1:0] src, input logic [31:0] im,
                           input logic [31:0] tp, input logic last,
                           input logic exp_fit, input logic [31:0] exp_word);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout in_ready=%b exp=1", in_ready);
      return;
    end
    in_valid = 1'b1;
    immsrc   = src;
    imm      = im;
    templ    = tp;
    in_last  = last;
    @(posedge clk);
    if (exp_fit) begin
      exp_q.push_back({cur_addr, exp_word});
      cur_addr = cur_addr + 32'd4;
      exp_wr++;
    end else begin
      exp_err++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_fit) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1) begin
        failures++;
        $display("FAIL write_latency mem_we=%b exp=1", mem_we);
      end
    end
  endtask

  task automatic wait_done();
    int n;
    logic seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      n++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout done=%b exp=1", done);
    end
    checks++;
    if (wr_count !== CNT_W'(exp_wr)) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=%0d", wr_count, exp_wr);
    end
    checks++;
    if (err_count !== CNT_W'(exp_err)) begin
      failures++;
      $display("FAIL err_count got=%0d exp=%0d", err_count, exp_err);
    end
    checks++;
    if (err_sticky !== (exp_err != 0)) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=%b", err_sticky, exp_err != 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got=0 exp=%0d", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL done_pulse done=%b state=%0d exp done=0 state=0", done, state_dbg);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    immsrc = 2'b00; imm = '0; templ = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, done, err_sticky} !== 4'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || wr_count !== '0 || err_count !== '0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_values rdy=%b we=%b done=%b addr=%h wd=%h wr=%0d err=%0d st=%0d exp all 0",
               in_ready, mem_we, done, mem_addr, mem_wdata, wr_count, err_count, state_dbg);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_i();
    // in_valid outside RUN must be ignored (monitor flags any write)
    @(negedge clk);
    in_valid = 1'b1; immsrc = IMM_I; imm = 32'd5; templ = 32'h13; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (state_dbg !== ST_IDLE || err_count !== '0) begin
      failures++;
      $display("FAIL idle_ignores_valid state=%0d err=%0d exp state=0 err=0", state_dbg, err_count);
    end
    do_start(32'h100);
    send_beat(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 1'b1, 32'hFFF0_0013);
    wait_done();
  endtask

  task automatic test_s_then_b();
    do_start(32'h200);
    send_beat(IMM_S, 32'h0000_07FF, 32'h0000_2023, 1'b0, 1'b1, 32'h7E00_2FA3);
    send_beat(IMM_B, 32'hFFFF_F000, 32'h0000_0063, 1'b1, 1'b1, 32'h8000_0063);
    wait_done();
  endtask

  task automatic test_rejects();
    do_start(32'h300);
    send_beat(IMM_B, 32'd3, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
    send_beat(IMM_I, 32'd2048, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    wait_done();
  endtask

  task automatic test_reset_in_write();
    int n;
    do_start(32'h400);
    send_beat(IMM_I, 32'd4096, 32'h13, 1'b0, 1'b0, 32'h0);
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; immsrc = IMM_I; imm = 32'd5; templ = 32'h13; in_last = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL reach_write mem_we=%b exp=1", mem_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, done, err_sticky} !== 4'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || wr_count !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_in_write rdy=%b we=%b done=%b addr=%h wd=%h wr=%0d err=%0d exp all 0",
               in_ready, mem_we, done, mem_addr, mem_wdata, wr_count, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    do_start(32'h500);
    checks++;
    if (err_count !== '0 || wr_count !== '0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear wr=%0d err=%0d sticky=%b exp 0", wr_count, err_count, err_sticky);
    end
    send_beat(IMM_I, 32'd7, 32'h0000_0093, 1'b1, 1'b1, 32'h0070_0093);
    wait_done();
  endtask

  task automatic test_wrap();
    do_start(32'hFFFF_FFFC);
    send_beat(IMM_I, 32'd1, 32'h13, 1'b0, 1'b1, 32'h0010_0013);
    checks++;
    if (cur_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_model got=%h exp=0", cur_addr);
    end
    send_beat(IMM_I, 32'd2, 32'h13, 1'b1, 1'b1, 32'h0020_0013);
    wait_done();
  endtask

  task automatic test_j();
    do_start(32'h600);
`ifdef IMM_J_TYPE_EN
    send_beat(IMM_J, 32'd2048, 32'h0000_006F, 1'b1, 1'b1, 32'h0010_006F);
`else
    send_beat(IMM_J, 32'd2048, 32'h0000_006F, 1'b1, 1'b0, 32'h0);
`endif
    wait_done();
  endtask

  task automatic test_random();
    logic [31:0] a;
    a = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} ;
    do_start(a);
    // start while in RUN must not move the address
    @(negedge clk);
    start = 1'b1; start_addr = 32'hDEAD_0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  s;
      logic [31:0] im, tp;
      logic [32:0] r;
      s  = 2'($urandom_range(0, 3));
      im = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 8191)) - 4096);
      tp = $urandom;
      r  = model(s, im, tp);
      send_beat(s, im, tp, i == 15, r[32], r[31:0]);
    end
    wait_done();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_i();
    test_s_then_b();
    test_rejects();
    test_reset_in_write();
    test_wrap();
    test_j();
    test_random();
    test_random();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encode_loader.md
Name: imm_encode_loader

Overview:
- Inverse of the immediate extender: takes a template instruction word plus a 32-bit signed immediate and an immsrc selector.
- Range-checks the immediate, scatters its bits into the I/S/B field positions, and streams the finished words into instruction memory through a single write port.
- Serves as the test/boot-time program loader of the single-cycle core.
- Round-trip contract: extending a loaded word with the same immsrc must reproduce the original immediate.

Parameters:
- ADDR_W, 32, width of the instruction-memory write address.
- CNT_W, 16, width of the written-word and error counters.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load session (honoured in IDLE only)
- start_addr  input  ADDR_W  first write address, byte address, word aligned
- in_valid  input  1  template/immediate beat valid
- in_ready  output  1  loader can accept a beat
- in_last  input  1  marks the final beat of the session
- immsrc  input  2  00 I-type, 01 S-type, 10 B-type, 11 J-type/reserved
- imm  input  32  signed immediate value
- templ  input  32  instruction word; its immediate fields are overwritten
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  32  encoded instruction
- done  output  1  one-cycle pulse at session end
- wr_count  output  CNT_W  words written this session
- err_count  output  CNT_W  beats rejected this session
- err_sticky  output  1  set on any rejection; cleared by start

Behaviour:
- Reset (async) values: state IDLE; in_ready, mem_we and done are 0; mem_addr, mem_wdata, wr_count and err_count are 0; err_sticky is 0.
  - Reset mid-session discards any captured word; no write occurs.
- FSM states: IDLE, RUN, WRITE, DONE.
  - IDLE: in_ready=0. On start, load mem_addr=start_addr, clear wr_count, err_count and err_sticky, then go to RUN.
  - RUN: in_ready=1. On in_valid, the beat is accepted in that cycle and in_ready drops.
    - Range-check fail: increment err_count, set err_sticky. Go to DONE if in_last, else stay in RUN. No write; the address does not advance.
    - Range-check pass: register mem_wdata = encoded word, register the last flag, go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle. Next cycle mem_addr += 4 (wraps modulo 2^ADDR_W) and wr_count += 1 (saturates at all-ones). Go to DONE if the registered last flag is set, else RUN.
  - DONE: done=1 for one cycle, then IDLE.
- Throughput and latency: at most one accepted beat per 2 cycles. An accepted beat appears on mem_we exactly 1 cycle after acceptance.
- start is ignored outside IDLE. in_valid is ignored outside RUN.
- Range rules:
  - I and S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - immsrc=11: rejected, unless the optional feature is enabled.
- Encoding (every templ bit outside the listed fields passes through unchanged):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- err_count saturates at all-ones.

Optional Feature:
- Macro IMM_J_TYPE_EN.
- Defined: immsrc=11 is J-type.
  - Range: imm[0]=0 and imm[31:20] all equal.
  - Encoding: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Undefined: immsrc=11 is always rejected (counted as an error, not written).

Decomposition:
- Shared package: immsrc constants (IMM_I, IMM_S, IMM_B, IMM_J); FSM state enum; ADDR_STEP=4.
- Sub-module imm_insert: combinational; inputs templ, imm, immsrc; outputs encoded word and fits flag. Honours IMM_J_TYPE_EN. This is the natural unit for exhaustive round-trip checking against the extender.

Test Plan:
- start_addr=0x100; one beat I-type, templ=0x00000013, imm=-1, in_last=1 → mem_we at 0x100 with 0xFFF00013; done pulses; wr_count=1.
- S-type, templ=0x00002023, imm=0x7FF, then B-type, templ=0x00000063, imm=-4096, last → words 0x7E002FA3 @A and 0x80000063 @A+4; wr_count=2.
- B-type imm=3 (odd), then I-type imm=2048 → both rejected; err_count=2; err_sticky=1; no mem_we.
- Reset asserted in the WRITE state → mem_we deasserts immediately; all outputs 0; next start re-clears the counters.
- start_addr=0xFFFFFFFC, two valid I beats → writes at 0xFFFFFFFC then 0x00000000 (wrap).
- immsrc=11, imm=2048, templ=0x0000006F → with IMM_J_TYPE_EN: 0x0010006F written; without: rejected and err_count=1.
